// File: rtl/mips_wb_pkg.sv
// Shared types for the MIPS writeback controller.
package mips_wb_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned KIND_W  = 2;
    localparam int unsigned LTYPE_W = 3;
    localparam int unsigned OFF_W   = 2;

    typedef enum logic [KIND_W-1:0] {
        KIND_ALU     = 2'd0,
        KIND_LOAD    = 2'd1,
        KIND_LINK    = 2'd2,
        KIND_ILLEGAL = 2'd3
    } wb_kind_t;

    typedef enum logic [LTYPE_W-1:0] {
        LW  = 3'd0,
        LB  = 3'd1,
        LBU = 3'd2,
        LH  = 3'd3,
        LHU = 3'd4,
        LWL = 3'd5,
        LWR = 3'd6
    } load_type_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        COMMIT   = 2'd2
    } wb_state_t;

endpackage

// File: rtl/mips_writeback_load_align.sv
// Load data extraction, extension and LWL/LWR merge (little-endian).
module mips_load_align
    import mips_wb_pkg::*;
(
    input  logic [XLEN-1:0]  rdata,
    input  load_type_t       load_type,
    input  logic [OFF_W-1:0] byte_offset,
    input  logic [XLEN-1:0]  old_value,
    output logic [XLEN-1:0]  result_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed byte/half, then extend or merge by load type.
    always_comb begin
        byte_sel = rdata[{byte_offset, 3'b000} +: 8];
        half_sel = byte_offset[1] ? rdata[31:16] : rdata[15:0];
        result_c = rdata;
        case (load_type)
            LB:  result_c = {{24{byte_sel[7]}}, byte_sel};
            LBU: result_c = {24'h000000, byte_sel};
            LH:  result_c = {{16{half_sel[15]}}, half_sel};
            LHU: result_c = {16'h0000, half_sel};
            LWL: begin
                case (byte_offset)
                    2'd0:    result_c = {rdata[7:0],  old_value[23:0]};
                    2'd1:    result_c = {rdata[15:0], old_value[15:0]};
                    2'd2:    result_c = {rdata[23:0], old_value[7:0]};
                    default: result_c = rdata;
                endcase
            end
            LWR: begin
                case (byte_offset)
                    2'd0:    result_c = rdata;
                    2'd1:    result_c = {old_value[31:24], rdata[31:8]};
                    2'd2:    result_c = {old_value[31:16], rdata[31:16]};
                    default: result_c = {old_value[31:8],  rdata[31:24]};
                endcase
            end
            default: result_c = rdata;
        endcase
    end

endmodule

// File: rtl/mips_writeback.sv
// Writeback controller: sole writer of the register file write port.
module mips_writeback
    import mips_wb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [KIND_W-1:0]   req_kind,
    input  logic [LTYPE_W-1:0]  req_load_type,
    input  logic [REG_W-1:0]    req_dest,
    input  logic [XLEN-1:0]     req_alu_result,
    input  logic [XLEN-1:0]     req_link,
    input  logic [OFF_W-1:0]    req_byte_offset,
    input  logic [XLEN-1:0]     req_old_value,
    output logic                mem_read,
    input  logic                mem_waitrequest,
    input  logic [XLEN-1:0]     mem_readdata,
    output logic                write_enable,
    output logic [REG_W-1:0]    write_register,
    output logic [XLEN-1:0]     write_data,
    output logic                timeout
);

    localparam int unsigned CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    wb_state_t          state_q, state_d;
    logic [REG_W-1:0]   dest_q, dest_d;
    load_type_t         load_type_q, load_type_d;
    logic [OFF_W-1:0]   byte_offset_q, byte_offset_d;
    logic [XLEN-1:0]    old_value_q, old_value_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               req_ready_q, req_ready_d;
    logic               mem_read_q, mem_read_d;
    logic               write_enable_q, write_enable_d;
    logic [REG_W-1:0]   write_register_q, write_register_d;
    logic [XLEN-1:0]    write_data_q, write_data_d;
    logic               timeout_q, timeout_d;

    wb_kind_t           kind_c;
    logic [CNT_W-1:0]   cnt_inc_c;
    logic [XLEN-1:0]    align_result_c;

    assign kind_c = wb_kind_t'(req_kind);

    mips_load_align u_align (
        .rdata       (mem_readdata),
        .load_type   (load_type_q),
        .byte_offset (byte_offset_q),
        .old_value   (old_value_q),
        .result_c    (align_result_c)
    );

    // Next-state, request latching and registered output computation.
    always_comb begin
        state_d          = state_q;
        dest_d           = dest_q;
        load_type_d      = load_type_q;
        byte_offset_d    = byte_offset_q;
        old_value_d      = old_value_q;
        wait_cnt_d       = wait_cnt_q;
        timeout_d        = timeout_q;
        write_enable_d   = 1'b0;
        write_register_d = write_register_q;
        write_data_d     = write_data_q;
        cnt_inc_c        = wait_cnt_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    dest_d        = req_dest;
                    load_type_d   = load_type_t'(req_load_type);
                    byte_offset_d = req_byte_offset;
                    old_value_d   = req_old_value;
                    if (kind_c == KIND_LOAD) begin
                        state_d    = MEM_WAIT;
                        wait_cnt_d = '0;
                    end else begin
                        state_d = COMMIT;
                        if (req_dest != '0) begin
                            write_enable_d   = 1'b1;
                            write_register_d = req_dest;
                            write_data_d     = (kind_c == KIND_LINK) ? req_link
                                                                     : req_alu_result;
                        end
                    end
                end
            end
            MEM_WAIT: begin
                if (!mem_waitrequest) begin
                    state_d = COMMIT;
                    if (dest_q != '0) begin
                        write_enable_d   = 1'b1;
                        write_register_d = dest_q;
                        write_data_d     = align_result_c;
                    end
                end else begin
                    wait_cnt_d = cnt_inc_c;
                    if (cnt_inc_c == CNT_W'(MAX_WAIT)) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE);
        mem_read_d  = (state_d == MEM_WAIT);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            dest_q           <= '0;
            load_type_q      <= LW;
            byte_offset_q    <= '0;
            old_value_q      <= '0;
            wait_cnt_q       <= '0;
            req_ready_q      <= 1'b1;
            mem_read_q       <= 1'b0;
            write_enable_q   <= 1'b0;
            write_register_q <= '0;
            write_data_q     <= '0;
            timeout_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            dest_q           <= dest_d;
            load_type_q      <= load_type_d;
            byte_offset_q    <= byte_offset_d;
            old_value_q      <= old_value_d;
            wait_cnt_q       <= wait_cnt_d;
            req_ready_q      <= req_ready_d;
            mem_read_q       <= mem_read_d;
            write_enable_q   <= write_enable_d;
            write_register_q <= write_register_d;
            write_data_q     <= write_data_d;
            timeout_q        <= timeout_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign mem_read       = mem_read_q;
    assign write_enable   = write_enable_q;
    assign write_register = write_register_q;
    assign write_data     = write_data_q;
    assign timeout        = timeout_q;

endmodule
